// File: rtl/key_debounce_multi_if.sv
// Key conditioner bus: raw key pins and repeat enable in, conditioned key events out.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic                repeat_en;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] led_toggle;

    // Board/control side: drives the pins and the repeat enable
    modport master (
        output key_in,
        output repeat_en,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat,
        input  led_toggle
    );

    // Conditioner side
    modport slave (
        input  key_in,
        input  repeat_en,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat,
        output led_toggle
    );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: synchroniser, ms-tick debounce, press/release pulses,
// long-press detection with optional auto-repeat, and a per-key LED toggle register.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    key_debounce_multi_if.slave bus
);

    localparam int unsigned PreDiv = CLK_FREQ_HZ / 1000;
    localparam int unsigned PreW   = (PreDiv > 1) ? $clog2(PreDiv) : 1;
    localparam int unsigned DbW    = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HoldW  = $clog2(LONG_MS + 1);
    localparam int unsigned RepW   = $clog2(REPEAT_MS + 1);

    // Pin level of a released key; synchronisers reset here so reset never looks like a press
    localparam logic [NUM_KEYS-1:0] RelLvl = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {StIdle, StHeld, StLong} hold_st_e;

    logic [PreW-1:0]     pre_q, pre_d;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [NUM_KEYS-1:0] led_q, led_d;

    logic [DbW-1:0]      db_cnt_q   [NUM_KEYS];
    logic [DbW-1:0]      db_cnt_d   [NUM_KEYS];
    logic [HoldW-1:0]    hold_cnt_q [NUM_KEYS];
    logic [HoldW-1:0]    hold_cnt_d [NUM_KEYS];
    logic [RepW-1:0]     rep_cnt_q  [NUM_KEYS];
    logic [RepW-1:0]     rep_cnt_d  [NUM_KEYS];
    hold_st_e            st_q       [NUM_KEYS];
    hold_st_e            st_d       [NUM_KEYS];

    assign tick  = (pre_q == PreW'(PreDiv - 1));
    assign pre_d = tick ? '0 : pre_q + PreW'(1);

    // Free-running millisecond prescaler shared by all channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Two-flop synchroniser on the raw pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RelLvl;
            sync2_q <= RelLvl;
        end else begin
            sync1_q <= bus.key_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so 1 always means pressed
    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Per-channel debounce, edge detection and hold/long/repeat FSM
    always_comb begin
        key_state_d = key_state_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        repeat_d    = '0;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        st_d        = st_q;

        for (int i = 0; i < NUM_KEYS; i++) begin
            // Debounce: a differing level must persist for DEBOUNCE_MS ticks
            if (pressed[i] == key_state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick) begin
                if (db_cnt_q[i] == DbW'(DEBOUNCE_MS - 1)) begin
                    db_cnt_d[i]    = '0;
                    key_state_d[i] = ~key_state_q[i];
                    press_d[i]     = ~key_state_q[i];
                    release_d[i]   = key_state_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end

            case (st_q[i])
                StIdle: begin
                    if (press_d[i]) begin
                        st_d[i]       = StHeld;
                        hold_cnt_d[i] = '0;
                    end
                end
                StHeld: begin
                    if (tick) begin
                        if (hold_cnt_q[i] == HoldW'(LONG_MS - 1)) begin
                            long_d[i]     = 1'b1;
                            st_d[i]       = StLong;
                            hold_cnt_d[i] = '0;
                            rep_cnt_d[i]  = '0;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
                        end
                    end
                end
                StLong: begin
                    if (!bus.repeat_en) begin
                        rep_cnt_d[i] = '0;
                    end else if (tick) begin
                        if (rep_cnt_q[i] == RepW'(REPEAT_MS - 1)) begin
                            repeat_d[i]  = 1'b1;
                            rep_cnt_d[i] = '0;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
                        end
                    end
                end
                default: st_d[i] = StIdle;
            endcase

            // Release wins over any long/repeat event in the same cycle
            if (release_d[i]) begin
                st_d[i]       = StIdle;
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
                long_d[i]     = 1'b0;
                repeat_d[i]   = 1'b0;
            end
        end
    end

    assign led_d = led_q ^ press_d;

    // Channel state and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            repeat_q    <= '0;
            led_q       <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
                st_q[i]       <= StIdle;
            end
        end else begin
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            led_q       <= led_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            st_q        <= st_d;
        end
    end

    assign bus.key_state   = key_state_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_long    = long_q;
    assign bus.key_repeat  = repeat_q;
    assign bus.led_toggle  = led_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed plan plus random key activity, every cycle compared
// against a tick-counting reference model of the key-conditioning rules.
module tb_key_debounce_multi;

    localparam int unsigned NK     = 4;
    localparam int unsigned CLKF   = 10_000;
    localparam int unsigned DEB    = 3;
    localparam int unsigned LONGMS = 10;
    localparam int unsigned REPMS  = 4;
    localparam int unsigned CPM    = CLKF / 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_debounce_multi_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_multi #(
        .NUM_KEYS   (NK),
        .CLK_FREQ_HZ(CLKF),
        .DEBOUNCE_MS(DEB),
        .LONG_MS    (LONGMS),
        .REPEAT_MS  (REPMS),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pin history, accepted level, and plain tick counts per key
    int          ncyc;
    logic [NK-1:0] m_s1, m_s2;
    logic [NK-1:0] m_state, m_press, m_rel, m_long, m_rep, m_led;
    int          m_db   [NK];
    int          m_held [NK];
    int          m_rc   [NK];
    int          seen_press [NK];
    int          seen_rep   [NK];

    task automatic model_reset();
        ncyc    = 0;
        m_s1    = '1;
        m_s2    = '1;
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        m_rep   = '0;
        m_led   = '0;
        for (int i = 0; i < NK; i++) begin
            m_db[i]   = 0;
            m_held[i] = 0;
            m_rc[i]   = 0;
        end
    endtask

    // Advance the model across one clock edge using the inputs currently applied
    task automatic model_edge();
        logic          tick;
        logic [NK-1:0] lvl;
        logic [NK-1:0] was;
        tick = ((ncyc % CPM) == CPM - 1);
        ncyc++;
        lvl  = ~m_s2;
        m_s2 = m_s1;
        m_s1 = kif.key_in;
        was  = m_state;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        m_rep   = '0;
        for (int i = 0; i < NK; i++) begin
            if (lvl[i] == m_state[i]) begin
                m_db[i] = 0;
            end else if (tick) begin
                m_db[i]++;
                if (m_db[i] == DEB) begin
                    m_db[i]    = 0;
                    m_state[i] = ~m_state[i];
                    if (m_state[i]) m_press[i] = 1'b1;
                    else            m_rel[i]   = 1'b1;
                end
            end
            if (!kif.repeat_en) m_rc[i] = 0;
            if (m_press[i] || m_rel[i]) begin
                m_held[i] = 0;
                m_rc[i]   = 0;
            end else if (was[i] && tick) begin
                if (m_held[i] < LONGMS) begin
                    m_held[i]++;
                    if (m_held[i] == LONGMS) m_long[i] = 1'b1;
                end else if (kif.repeat_en) begin
                    m_rc[i]++;
                    if (m_rc[i] == REPMS) begin
                        m_rep[i] = 1'b1;
                        m_rc[i]  = 0;
                    end
                end
            end
            if (m_press[i]) m_led[i] = ~m_led[i];
        end
    endtask

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"},   kif.key_state,   '0);
        check({tag, "_press"},   kif.key_press,   '0);
        check({tag, "_release"}, kif.key_release, '0);
        check({tag, "_long"},    kif.key_long,    '0);
        check({tag, "_repeat"},  kif.key_repeat,  '0);
        check({tag, "_led"},     kif.led_toggle,  '0);
    endtask

    // One clock: step the model, then compare every output 1 time unit after the edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("key_state",   kif.key_state,   m_state);
        check("key_press",   kif.key_press,   m_press);
        check("key_release", kif.key_release, m_rel);
        check("key_long",    kif.key_long,    m_long);
        check("key_repeat",  kif.key_repeat,  m_rep);
        check("led_toggle",  kif.led_toggle,  m_led);
        for (int i = 0; i < NK; i++) begin
            if (kif.key_press[i])  seen_press[i]++;
            if (kif.key_repeat[i]) seen_rep[i]++;
        end
    endtask

    // kind: 0 press, 1 release, 2 long, 3 repeat; n = cycles until the pulse
    task automatic wait_pulse(input int ch, input int kind, input int maxc, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < maxc) begin
            cycle();
            n++;
            case (kind)
                0:       hit = kif.key_press[ch];
                1:       hit = kif.key_release[ch];
                2:       hit = kif.key_long[ch];
                default: hit = kif.key_repeat[ch];
            endcase
        end
        vectors++;
        assert (hit) else begin
            miscompares++;
            $error("FAIL timeout kind=%0d ch=%0d observed no pulse in %0d cycles, expected one",
                   kind, ch, maxc);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NK; i++) begin
            seen_press[i] = 0;
            seen_rep[i]   = 0;
        end
        rst           = 1'b1;
        kif.key_in    = '1;
        kif.repeat_en = 1'b0;
        model_reset();

        // Reset held with all keys released
        repeat (5) begin
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (200) cycle();

        // Clean press and release on key 0
        kif.key_in[0] = 1'b0;
        wait_pulse(0, 0, 40, n);
        check_range("k0_press_latency", n, 22, 32);
        check("k0_led_after_press", kif.led_toggle, 4'b0001);
        repeat (30) cycle();
        kif.key_in[0] = 1'b1;
        wait_pulse(0, 1, 40, n);
        check_range("k0_release_latency", n, 22, 32);
        check("k0_led_after_release", kif.led_toggle, 4'b0001);
        repeat (40) cycle();

        // Bouncing key 1: toggles every 3 clk, then settles pressed
        seen_press[1] = 0;
        for (int b = 0; b < 34; b++) begin
            kif.key_in[1] = ~kif.key_in[1];
            repeat (3) cycle();
        end
        check_int("k1_press_during_bounce", seen_press[1], 0);
        kif.key_in[1] = 1'b0;
        wait_pulse(1, 0, 40, n);
        check_range("k1_press_latency", n, 22, 32);
        repeat (40) cycle();
        check_int("k1_press_count", seen_press[1], 1);
        kif.key_in[1] = 1'b1;
        wait_pulse(1, 1, 40, n);

        // Long hold on key 2 with auto-repeat, then repeat disabled
        kif.repeat_en = 1'b1;
        kif.key_in[2] = 1'b0;
        wait_pulse(2, 0, 40, n);
        wait_pulse(2, 2, 120, n);
        check_range("k2_long_after_press", n, 90, 100);
        wait_pulse(2, 3, 50, n);
        check_int("k2_repeat_interval_1", n, REPMS * CPM);
        wait_pulse(2, 3, 50, n);
        check_int("k2_repeat_interval_2", n, REPMS * CPM);
        kif.repeat_en = 1'b0;
        seen_rep[2]   = 0;
        repeat (100) cycle();
        check_int("k2_no_repeat_when_disabled", seen_rep[2], 0);
        kif.key_in[2] = 1'b1;
        wait_pulse(2, 1, 40, n);
        repeat (20) cycle();

        // Keys 0 and 3 pressed on the same cycle; LEDs 0..2 were already 1, so LED 0 flips off
        kif.key_in[0] = 1'b0;
        kif.key_in[3] = 1'b0;
        wait_pulse(0, 0, 40, n);
        check("dual_press", kif.key_press, 4'b1001);
        check("dual_led", kif.led_toggle, 4'b1110);
        wait_pulse(0, 2, 120, n);
        check("dual_long", kif.key_long, 4'b1001);
        repeat (5) cycle();

        // Asynchronous reset while keys are in long-hold
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_pulse(0, 0, 40, n);
        check_range("repress_after_reset", n, 22, 32);
        check("repress_both", kif.key_press, 4'b1001);
        check("repress_led", kif.led_toggle, 4'b1001);
        kif.key_in = '1;
        repeat (60) cycle();

        // Random key activity; pressed keys tend to stay down longer
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (kif.key_in[i]) begin
                    if ($urandom_range(0, 89) == 0) kif.key_in[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 199) == 0) kif.key_in[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 299) == 0) kif.repeat_en = ~kif.repeat_en;
            cycle();
        end
        kif.key_in = '1;
        repeat (60) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
